// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and request-classification helpers for lsu_mem_ctrl.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StLdWait,
        StRmwWait,
        StResp
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response handshake plus word-wide data-memory bus for lsu_mem_ctrl.
interface lsu_mem_ctrl_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  ready, done, rdata, err, mem_address, mem_read, mem_write, mem_wdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output ready, done, rdata, err, mem_address, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts and extends load values, merges sub-word store data into a word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane ignores addr_lo[0]; misaligned halves are truncated when not trapped.
    always_comb begin
        byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    end

    always_comb begin
        load_val = mem_rdata;
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'b0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'b0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_word = mem_rdata;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = mem_rdata;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer for RV32I: sub-word loads, read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with err.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);

    lsu_state_e    state_q;
    logic [2:0]    funct3_q;
    logic [1:0]    lo_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] rdata_q;
    logic          done_q;
    logic          err_q;

    logic          trap;
    logic          bad_req;
    logic [31:0]   load_val;
    logic [31:0]   store_word;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(bus.funct3, bus.addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign bad_req = !f3_legal(bus.we, bus.funct3) || trap;

    lsu_lane u_lane (
        .mem_rdata  (bus.mem_rdata),
        .addr_lo    (lo_q),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    assign bus.ready = (state_q == StIdle);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    // Strobes go out in the accept cycle so memory latency overlaps the handshake.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_address = waddr_q;
        case (state_q)
            StIdle: begin
                bus.mem_address = {bus.addr[AW-1:2], 2'b00};
                if (bus.req && !bad_req) begin
                    if (bus.we && (bus.funct3 == F3_W)) begin
                        bus.mem_write = 1'b1;
                        bus.mem_wdata = bus.wdata;
                    end else begin
                        bus.mem_read = 1'b1;
                    end
                end
            end
            StRmwWait: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = store_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            funct3_q <= 3'b000;
            lo_q     <= 2'b00;
            wdata_q  <= '0;
            waddr_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        funct3_q <= bus.funct3;
                        lo_q     <= bus.addr[1:0];
                        wdata_q  <= bus.wdata;
                        waddr_q  <= {bus.addr[AW-1:2], 2'b00};
                        if (bad_req) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end else if (!bus.we) begin
                            state_q <= StLdWait;
                        end else if (bus.funct3 == F3_W) begin
                            done_q  <= 1'b1;
                            state_q <= StResp;
                        end else begin
                            state_q <= StRmwWait;
                        end
                    end
                end
                StLdWait: begin
                    rdata_q <= load_val;
                    done_q  <= 1'b1;
                    state_q <= StResp;
                end
                StRmwWait: begin
                    done_q  <= 1'b1;
                    state_q <= StResp;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
